// File: rtl/seq_binary_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Digits above DIGITS are discarded; any bit lost off the top raises overflow.
module seq_binary_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [WIDTH-1:0] bin_reg;
    logic [BW-1:0]   work;
    logic            ovf_acc;
    logic [CW-1:0]   cnt;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    next_work;
    logic [WIDTH-1:0] next_bin;
    logic             out_bit;

    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        next_work = {adj[BW-2:0], bin_reg[WIDTH-1]};
        next_bin  = {bin_reg[WIDTH-2:0], 1'b0};
        out_bit   = adj[BW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_reg  <= '0;
            work     <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_reg <= data;
                        work    <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    work    <= next_work;
                    bin_reg <= next_bin;
                    ovf_acc <= ovf_acc | out_bit;
                    cnt     <= cnt - CW'(1);
                    // Final bit: publish the shifted value, not the stale one.
                    if (cnt == CW'(1)) begin
                        bcd      <= next_work;
                        overflow <= ovf_acc | out_bit;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Bench for seq_binary_to_bcd: three configurations driven in parallel,
// results compared with a decimal-arithmetic reference.
module tb_seq_binary_to_bcd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data;

    logic        busy0, done0, ovf0;
    logic [11:0] bcd0;
    logic        busy1, done1, ovf1;
    logic [7:0]  bcd1;
    logic        busy2, done2, ovf2;
    logic [19:0] bcd2;

    int total = 0;
    int bad   = 0;

    logic [31:0] prev0, prev1, prev2;

    always #5 clk = ~clk;

    seq_binary_to_bcd #(.WIDTH(8), .DIGITS(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data[7:0]),
        .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0)
    );

    seq_binary_to_bcd #(.WIDTH(8), .DIGITS(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data[7:0]),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
    );

    seq_binary_to_bcd #(.WIDTH(16), .DIGITS(5)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int nd);
        int m = 1;
        for (int i = 0; i < nd; i++) m = m * 10;
        return m;
    endfunction

    function automatic logic [31:0] ref_bcd(input int v, input int nd);
        logic [31:0] b = '0;
        int r = v % pow10(nd);
        for (int i = 0; i < nd; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic logic [31:0] ref_ovf(input int v, input int nd);
        return {31'b0, v >= pow10(nd)};
    endfunction

    task automatic run(input int v);
        int v8 = v % 256;
        int d0 = -1, d1 = -1, d2 = -1;
        int n0 = 0, n1 = 0, n2 = 0;
        logic excl = 1'b0;
        logic held = 1'b1;
        @(negedge clk);
        start = 1'b1;
        data  = 16'(v);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {29'b0, busy0, busy1, busy2}, 32'h7);
        for (int j = 0; j <= 20; j++) begin
            if (j > 0) @(negedge clk);
            excl |= (busy0 & done0) | (busy1 & done1) | (busy2 & done2);
            if (done0) begin n0++; if (d0 < 0) d0 = j; end
            if (done1) begin n1++; if (d1 < 0) d1 = j; end
            if (done2) begin n2++; if (d2 < 0) d2 = j; end
            if (d0 < 0 && 32'(bcd0) != prev0) held = 1'b0;
            if (d1 < 0 && 32'(bcd1) != prev1) held = 1'b0;
            if (d2 < 0 && 32'(bcd2) != prev2) held = 1'b0;
        end
        check("busy_done_excl", {31'b0, excl}, 0);
        check("no_intermediate", {31'b0, held}, 1);
        check("lat_d3", 32'(d0), 8);
        check("lat_d2", 32'(d1), 8);
        check("lat_w16", 32'(d2), 16);
        check("pulses", 32'(n0 + n1 + n2), 3);
        check("bcd_d3", 32'(bcd0), ref_bcd(v8, 3));
        check("ovf_d3", 32'(ovf0), ref_ovf(v8, 3));
        check("bcd_d2", 32'(bcd1), ref_bcd(v8, 2));
        check("ovf_d2", 32'(ovf1), ref_ovf(v8, 2));
        check("bcd_w16", 32'(bcd2), ref_bcd(v, 5));
        check("ovf_w16", 32'(ovf2), ref_ovf(v, 5));
        prev0 = ref_bcd(v8, 3);
        prev1 = ref_bcd(v8, 2);
        prev2 = ref_bcd(v, 5);
    endtask

    task automatic busy_ignore();
        int d = -1;
        @(negedge clk);
        start = 1'b1;
        data  = 16'd200;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 20 && d < 0; j++) begin
            @(negedge clk);
            if (j == 3) begin
                start = 1'b1;
                data  = 16'd7;
            end else begin
                start = 1'b0;
            end
            if (done0) d = j;
        end
        check("ign_lat", 32'(d), 8);
        check("ign_bcd_d3", 32'(bcd0), 32'h200);
        check("ign_bcd_d2", 32'(bcd1), 32'h00);
        check("ign_ovf_d2", 32'(ovf1), 1);
        start = 1'b1;
        data  = 16'd42;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_drop", 32'(done0), 0);
        check("b2b_busy", 32'(busy0), 1);
        d = -1;
        for (int j = 1; j <= 20 && d < 0; j++) begin
            @(negedge clk);
            if (done0) d = j;
        end
        check("b2b_lat", 32'(d), 8);
        check("b2b_bcd_d3", 32'(bcd0), 32'h042);
        check("b2b_bcd_d2", 32'(bcd1), 32'h42);
        check("b2b_ovf_d2", 32'(ovf1), 0);
        repeat (10) @(negedge clk);
        check("b2b_bcd_w16", 32'(bcd2), 32'h00200);
        prev0 = 32'h042;
        prev1 = 32'h42;
        prev2 = 32'h00200;
    endtask

    task automatic reset_mid();
        logic any_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        data  = 16'd129;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {29'b0, busy0, busy1, busy2}, 0);
        check("rst_done", {29'b0, done0, done1, done2}, 0);
        check("rst_bcd_d3", 32'(bcd0), 0);
        check("rst_bcd_d2", 32'(bcd1), 0);
        check("rst_bcd_w16", 32'(bcd2), 0);
        check("rst_ovf", {29'b0, ovf0, ovf1, ovf2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            any_done |= done0 | done1 | done2 | busy0 | busy1 | busy2;
        end
        check("rst_quiet", {31'b0, any_done}, 0);
        prev0 = 0;
        prev1 = 0;
        prev2 = 0;
        run(33);
    endtask

    initial begin
        int directed[10] = '{5, 10, 129, 101, 49, 255, 0, 99, 65535, 1000};
        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
        prev0 = 0;
        prev1 = 0;
        prev2 = 0;
        repeat (2) @(negedge clk);
        check("init_busy", {29'b0, busy0, busy1, busy2}, 0);
        check("init_done", {29'b0, done0, done1, done2}, 0);
        check("init_bcd", 32'(bcd0) | 32'(bcd1) | 32'(bcd2), 0);
        check("init_ovf", {29'b0, ovf0, ovf1, ovf2}, 0);
        rst_n = 1'b1;
        foreach (directed[i]) run(directed[i]);
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) run(int'($urandom_range(0, 255)));
            else run(int'($urandom_range(0, 65535)));
        end
        busy_ignore();
        run(255);
        reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
